arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter N, default 4, number of input channels (2..16, non-power-of-2 permitted).
REQ-002 Parameter W, default 8, data width in bits (1..64).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 mode  input  1  0 = manual select, 1 = round-robin arbitration.
REQ-007 s  input  clog2(N)  channel select, used in manual mode only.
REQ-008 in_valid  input  N  per-channel data valid.
REQ-009 in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-010 in_ready  output  N  per-channel accept, combinational.
REQ-011 y_valid  output  1  registered output valid.
REQ-012 y_ready  input  1  downstream accept.
REQ-013 y  output  W  registered output data.
REQ-014 y_ch  output  clog2(N)  source channel of the current y.
REQ-015 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-016 free SHALL equal (!y_valid || y_ready); the output register SHALL load only when free.
REQ-017 Manual mode: grant SHALL be channel s when s < N and in_valid[s] = 1; otherwise there is no grant.
REQ-018 Manual mode with s >= N SHALL grant nothing, with all in_ready = 0; no X SHALL propagate.
REQ-019 Round-robin mode: grant SHALL be the first i with in_valid[i] = 1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-020 in_ready[i] SHALL be 1 only when free = 1 and grant = i; at most one bit SHALL be set.
REQ-021 A transfer on channel g occurs when in_valid[g] and in_ready[g] are both 1. On the next edge: y <= in_data[g], y_ch <= g, y_valid <= 1.
REQ-022 In round-robin mode, after a transfer on g, ptr SHALL become (g+1) mod N, wrapping at N rather than at 2^clog2(N).
REQ-023 ptr SHALL hold when no round-robin transfer occurs and throughout manual mode.
REQ-024 When free = 1 and there is no grant, y_valid SHALL become 0. y and y_ch SHALL then hold their previous values.
REQ-025 When y_valid = 1 and y_ready = 0, y, y_ch and y_valid SHALL hold and all in_ready SHALL be 0 (backpressure).
REQ-026 Simultaneous y_ready and a new grant SHALL give back-to-back transfers: one word per cycle at full throughput.
REQ-027 Latency from input transfer to y_valid SHALL be exactly 1 cycle.
REQ-028 xfer_cnt SHALL increment by 1 on each edge where y_valid = 1 and y_ready = 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-029 A mode or s change SHALL affect only the next grant decision. A word already in the register SHALL be unaffected.
REQ-030 Behaviour SHALL not depend on in_data of non-granted channels.

Reset
REQ-031 While reset = 1: y_valid = 0, y = 0, y_ch = 0, ptr = 0, xfer_cnt = 0. These values SHALL apply immediately, independent of clk.
REQ-032 in_ready SHALL be forced to 0 while reset = 1.
REQ-033 Reset asserted mid-operation SHALL discard any held word without a transfer and without incrementing xfer_cnt.
REQ-034 After reset deasserts, the first grant SHALL occur on the first rising edge at which reset = 0.

Verification (N=4, W=8)
REQ-035 Manual mode:
- Stimulus: mode=0, s=1, in_valid=4'b0011, in_data ch0=5, ch1=10, y_ready=1.
- Required: in_ready=4'b0010; after 1 cycle y=10, y_ch=1; then s=0 gives y=5, y_ch=0.
REQ-036 Round-robin fairness:
- Stimulus: mode=1, all in_valid=1, data ch0..ch3=8'hA0..8'hA3, y_ready=1.
- Required: y_ch sequence 0,1,2,3,0,1 on consecutive cycles; xfer_cnt=6 after 6 transfers.
REQ-037 Backpressure:
- Stimulus: y holds 8'd255 from ch2; y_ready=0 for 5 cycles with in_valid=4'b1111.
- Required: y=255 stable, y_ch=2, in_ready=0 throughout, ptr unchanged; on y_ready=1 the next grant is ch3.
REQ-038 Skip and wrap:
- Stimulus: mode=1, ptr=3, in_valid=4'b0101.
- Required: grants ch0, then ch2, then ch0; with in_valid=0, y_valid drops to 0 after the last word is accepted.
REQ-039 Invalid select:
- Stimulus: mode=0, s=3, in_valid[3]=0, then mode=0 with N=3, s=3.
- Required: no grant, in_ready=0, y_valid=0, no X on any output.
REQ-040 Reset mid-operation and counter wrap:
- Reset stimulus: reset pulse while y_valid=1, y=8'd127.
- Reset required: y_valid=0, y=0, y_ch=0, ptr=0, xfer_cnt=0, with no clock edge needed.
- Wrap stimulus: run 65537 transfers.
- Wrap required: xfer_cnt=1.

Source files
------------

// File: rtl/arb_mux.sv
// N-channel arbitrating multiplexer with a single registered output slot.
// Grants by manual select or round-robin, and supports backpressure and full-throughput streaming.
module arb_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] s,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [W-1:0]         y,
  output logic [$clog2(N)-1:0] y_ch,
  output logic [15:0]          xfer_cnt
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic          y_valid_q, y_valid_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] y_ch_q, y_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          free;
  logic          load;
  int            dist_c;
  int            best_c;

  assign free = !y_valid_q || y_ready;
  assign load = free && gnt_vld;

  // Round-robin picks the valid channel at the smallest circular distance from ptr.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    dist_c   = 0;
    best_c   = N;
    for (int i = 0; i < N; i++) begin
      if (!mode) begin
        if (s == SW'(i) && in_valid[i]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = SW'(i);
          gnt_data = in_data[i*W +: W];
        end
      end else begin
        dist_c = i - int'(ptr_q);
        if (dist_c < 0) dist_c = dist_c + N;
        if (in_valid[i] && dist_c < best_c) begin
          best_c   = dist_c;
          gnt_vld  = 1'b1;
          gnt_idx  = SW'(i);
          gnt_data = in_data[i*W +: W];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !reset && load && (gnt_idx == SW'(i));
    end
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (free) begin
      y_valid_d = gnt_vld;
      if (gnt_vld) begin
        y_d    = gnt_data;
        y_ch_d = gnt_idx;
      end
    end
    if (mode && load) begin
      ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + SW'(1);
    end
    if (y_valid_q && y_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
      y_ch_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign y_valid  = y_valid_q;
  assign y        = y_q;
  assign y_ch     = y_ch_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux (N=4, W=8 main instance; N=3 instance for the out-of-range select case).
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  s = '0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic        y_ready = 1'b0;
  logic [3:0]  in_ready;
  logic        y_valid;
  logic [7:0]  y;
  logic [1:0]  y_ch;
  logic [15:0] xfer_cnt;

  logic [1:0]  s3 = '0;
  logic [2:0]  v3 = '0;
  logic [23:0] d3 = '0;
  logic [2:0]  r3;
  logic        yv3;
  logic [7:0]  y3;
  logic [1:0]  ch3;
  logic [15:0] cnt3;

  int vec = 0;
  int miss = 0;

  // Reference state of the output slot and the round-robin pointer
  bit          m_vld;
  logic [7:0]  m_y;
  int          m_ch;
  int          m_ptr;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  arb_mux #(.N(4), .W(8)) dut (
    .clk(clk), .reset(reset), .mode(mode), .s(s), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .y_valid(y_valid), .y_ready(y_ready), .y(y), .y_ch(y_ch),
    .xfer_cnt(xfer_cnt)
  );

  arb_mux #(.N(3), .W(8)) dut3 (
    .clk(clk), .reset(reset), .mode(1'b0), .s(s3), .in_valid(v3), .in_data(d3),
    .in_ready(r3), .y_valid(yv3), .y_ready(1'b1), .y(y3), .y_ch(ch3), .xfer_cnt(cnt3)
  );

  function automatic int ref_grant();
    if (!mode) return in_valid[s] ? int'(s) : -1;
    for (int k = 0; k < 4; k++) begin
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = ref_grant();
    if (reset || !(!m_vld || y_ready) || g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_clear();
    m_vld = 0; m_y = '0; m_ch = 0; m_ptr = 0; m_cnt = '0;
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick();
    int g;
    bit fr;
    bit nv;
    logic [7:0] ny;
    int nch, np;
    logic [15:0] nc;
    g = ref_grant();
    fr = !m_vld || y_ready;
    nv = m_vld; ny = m_y; nch = m_ch; np = m_ptr;
    nc = m_cnt + ((m_vld && y_ready) ? 16'd1 : 16'd0);
    if (fr) begin
      if (g >= 0) begin
        ny = in_data[g*8 +: 8];
        nch = g;
        nv = 1;
        if (mode) np = (g + 1) % 4;
      end else begin
        nv = 0;
      end
    end
    @(posedge clk);
    #1;
    m_vld = nv; m_y = ny; m_ch = nch; m_ptr = np; m_cnt = nc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mode = 1'b1; in_valid = 4'b1111; y_ready = 1'b1; in_data = 32'hDEADBEEF;
    #1;
    vec++;
    if ({y_valid, y, y_ch, xfer_cnt, in_ready} !== 31'd0) begin
      miss++;
      $display("FAIL reset_async: got vld=%b y=%h ch=%0d cnt=%0d rdy=%b, want all zero",
               y_valid, y, y_ch, xfer_cnt, in_ready);
    end
    @(posedge clk);
    #1;
    vec++;
    if ({y_valid, y, y_ch, xfer_cnt, in_ready} !== 31'd0) begin
      miss++;
      $display("FAIL reset_held: got vld=%b y=%h ch=%0d cnt=%0d rdy=%b, want all zero",
               y_valid, y, y_ch, xfer_cnt, in_ready);
    end
    in_valid = '0;
    model_clear();
    reset = 1'b0;
  endtask

  task automatic test_manual();
    do_reset();
    mode = 1'b0; s = 2'd1; in_valid = 4'b0011; in_data = {8'd0, 8'd0, 8'd10, 8'd5}; y_ready = 1'b1;
    #1;
    vec++;
    if (in_ready !== 4'b0010) begin
      miss++; $display("FAIL manual_ready1: got %b want 0010", in_ready);
    end
    tick();
    vec++;
    if (y !== 8'd10 || y_ch !== 2'd1 || y_valid !== 1'b1) begin
      miss++; $display("FAIL manual_ch1: got y=%0d ch=%0d vld=%b want 10/1/1", y, y_ch, y_valid);
    end
    s = 2'd0;
    #1;
    vec++;
    if (in_ready !== 4'b0001) begin
      miss++; $display("FAIL manual_ready0: got %b want 0001", in_ready);
    end
    tick();
    vec++;
    if (y !== 8'd5 || y_ch !== 2'd0) begin
      miss++; $display("FAIL manual_ch0: got y=%0d ch=%0d want 5/0", y, y_ch);
    end
  endtask

  task automatic test_rr_fair();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'hA3A2A1A0; y_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vec++;
      if (y_ch !== 2'(i % 4) || y !== 8'hA0 + 8'(i % 4) || y_valid !== 1'b1) begin
        miss++; $display("FAIL rr_seq%0d: got ch=%0d y=%h want ch=%0d", i, y_ch, y, i % 4);
      end
    end
    in_valid = '0;
    tick();
    vec++;
    if (xfer_cnt !== 16'd6) begin
      miss++; $display("FAIL rr_count: got %0d want 6", xfer_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; in_valid = 4'b0100; in_data = 32'h00FF0000; y_ready = 1'b1;
    tick();
    in_valid = 4'b1111; in_data = 32'h44332211; y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec++;
      if (in_ready !== 4'b0000) begin
        miss++; $display("FAIL bp_ready%0d: got %b want 0000", i, in_ready);
      end
      tick();
      vec++;
      if (y !== 8'd255 || y_ch !== 2'd2 || y_valid !== 1'b1) begin
        miss++; $display("FAIL bp_hold%0d: got y=%0d ch=%0d vld=%b want 255/2/1", i, y, y_ch, y_valid);
      end
    end
    y_ready = 1'b1;
    #1;
    vec++;
    if (in_ready !== 4'b1000) begin
      miss++; $display("FAIL bp_release_ready: got %b want 1000", in_ready);
    end
    tick();
    vec++;
    if (y_ch !== 2'd3 || y !== 8'h44) begin
      miss++; $display("FAIL bp_next: got ch=%0d y=%h want 3/44", y_ch, y);
    end
  endtask

  task automatic test_skip_wrap();
    int exp_seq [3] = '{0, 2, 0};
    do_reset();
    mode = 1'b1; in_valid = 4'b0100; in_data = 32'h0C0B0A09; y_ready = 1'b1;
    tick();
    in_valid = 4'b0101;
    for (int j = 0; j < 3; j++) begin
      #1;
      vec++;
      if (in_ready !== 4'(1 << exp_seq[j])) begin
        miss++; $display("FAIL skip_ready%0d: got %b want ch%0d", j, in_ready, exp_seq[j]);
      end
      tick();
      vec++;
      if (y_ch !== 2'(exp_seq[j])) begin
        miss++; $display("FAIL skip_ch%0d: got %0d want %0d", j, y_ch, exp_seq[j]);
      end
    end
    in_valid = 4'b0000;
    tick();
    vec++;
    if (y_valid !== 1'b0 || y_ch !== 2'd0) begin
      miss++; $display("FAIL skip_drain: got vld=%b ch=%0d want 0/0", y_valid, y_ch);
    end
  endtask

  task automatic test_invalid_sel();
    mode = 1'b0; s = 2'd3; in_valid = 4'b0111; y_ready = 1'b1;
    s3 = 2'd3; v3 = 3'b111; d3 = 24'h123456;
    #1;
    vec++;
    if (in_ready !== 4'b0000 || r3 !== 3'b000) begin
      miss++; $display("FAIL inv_ready: got n4=%b n3=%b want 0", in_ready, r3);
    end
    tick();
    vec++;
    if (y_valid !== 1'b0 || yv3 !== 1'b0) begin
      miss++; $display("FAIL inv_valid: got n4=%b n3=%b want 0", y_valid, yv3);
    end
    vec++;
    if ($isunknown({in_ready, y_valid, y, y_ch, xfer_cnt, r3, yv3, y3, ch3, cnt3})) begin
      miss++; $display("FAIL inv_noX: got X on an output, want none");
    end
    v3 = '0;
  endtask

  task automatic test_random();
    logic [3:0] er;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1);
      s = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      in_data = $urandom;
      y_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready();
      vec++;
      if (in_ready !== er) begin
        miss++; $display("FAIL rand_ready%0d: got %b want %b", i, in_ready, er);
      end
      tick();
      vec++;
      if (y_valid !== m_vld || y !== m_y || y_ch !== 2'(m_ch) || xfer_cnt !== m_cnt) begin
        miss++;
        $display("FAIL rand_out%0d: got vld=%b y=%h ch=%0d cnt=%0d want %b/%h/%0d/%0d",
                 i, y_valid, y, y_ch, xfer_cnt, m_vld, m_y, m_ch, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; in_data = 32'h0000007F; y_ready = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    vec++;
    if ({y_valid, y, y_ch, xfer_cnt, in_ready} !== 31'd0) begin
      miss++;
      $display("FAIL reset_mid: got vld=%b y=%h ch=%0d cnt=%0d rdy=%b, want all zero",
               y_valid, y, y_ch, xfer_cnt, in_ready);
    end
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    y_ready = 1'b1; in_valid = 4'b0010; in_data = 32'h00005500;
    #1;
    vec++;
    if (in_ready !== 4'b0010) begin
      miss++; $display("FAIL reset_first_ready: got %b want 0010", in_ready);
    end
    tick();
    vec++;
    if (y_valid !== 1'b1 || y_ch !== 2'd1 || y !== 8'h55 || xfer_cnt !== 16'd0) begin
      miss++; $display("FAIL reset_first_grant: got vld=%b ch=%0d y=%h cnt=%0d want 1/1/55/0",
                       y_valid, y_ch, y, xfer_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h87654321; y_ready = 1'b1;
    for (int i = 0; i < 65538; i++) tick();
    vec++;
    if (xfer_cnt !== 16'd1) begin
      miss++; $display("FAIL wrap_count: got %0d want 1", xfer_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_fair();
    test_backpressure();
    test_skip_wrap();
    test_invalid_sel();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
